cdb_arbiter: RTL

Transmitter side of the common data bus (CDB). Collects completed results from the ALU and the load/store unit, buffers each source in a small FIFO, and drives a single registered tag/data broadcast. Reservation stations and the ROB receive that broadcast and match on tag. One broadcast per cycle, round-robin between sources, with ready/valid backpressure to the producers.

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_fifo.sv | 70 +++++++
 rtl/cdb_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the CDB transmitter: source ids, default widths, the null ROB tag.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 4;
  localparam int ZERO_ROB   = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LS  = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LS : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result buffer: circular store with head/tail pointers and an occupancy count.
// Write visible at the head one edge after push; caller must not push when full or pop when empty.
module cdb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdat_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (ena_i) begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && ena_i && !flush_i && push_i) begin
      mem_q[wr_q] <= wdat_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(ena_i && !flush_i && push_i && !pop_i && (cnt_q == CW'(DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
    !(ena_i && !flush_i && pop_i && (cnt_q == '0)));

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: buffers ALU and LS results, round-robin selects one per cycle into a registered tag/data broadcast.
// Define CDB_BYPASS_EN to let a winning result that arrives at an empty FIFO skip it (one-edge latency instead of two).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ls_valid,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_data,
  output logic              ls_ready,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
);

  localparam int                W        = TAG_W + DATA_W;
  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [TAG_W-1:0]  NO_TAG   = TAG_W'(ZERO_ROB);

  logic [W-1:0]  alu_head, ls_head;
  logic          alu_empty, ls_empty;
  logic [CW-1:0] alu_cnt, ls_cnt;

  logic active;
  logic alu_xfer, ls_xfer;
  logic alu_live, ls_live;
  logic alu_byp_cand, ls_byp_cand;
  logic alu_req, ls_req;
  logic grant_alu, grant_ls;
  logic alu_byp, ls_byp;
  logic alu_push, ls_push;
  logic alu_pop, ls_pop;

  src_e              ptr_q, ptr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
  assign alu_ready = rst & ena & (alu_cnt < FULL_CNT);
  assign ls_ready  = rst & ena & (ls_cnt < FULL_CNT);

  assign active   = rst & ena & ~flush;
  assign alu_xfer = active & alu_valid & alu_ready;
  assign ls_xfer  = active & ls_valid & ls_ready;
  assign alu_live = alu_xfer & (alu_tag != NO_TAG);
  assign ls_live  = ls_xfer & (ls_tag != NO_TAG);

`ifdef CDB_BYPASS_EN
  assign alu_byp_cand = alu_live & alu_empty;
  assign ls_byp_cand  = ls_live & ls_empty;
`else
  assign alu_byp_cand = 1'b0;
  assign ls_byp_cand  = 1'b0;
`endif

  assign alu_req = ~alu_empty | alu_byp_cand;
  assign ls_req  = ~ls_empty | ls_byp_cand;

  always_comb begin
    grant_alu = 1'b0;
    grant_ls  = 1'b0;
    if (alu_req && ls_req) begin
      grant_alu = (ptr_q == SRC_ALU);
      grant_ls  = (ptr_q == SRC_LS);
    end else begin
      grant_alu = alu_req;
      grant_ls  = ls_req;
    end
  end

  assign alu_byp  = grant_alu & alu_byp_cand;
  assign ls_byp   = grant_ls & ls_byp_cand;
  assign alu_pop  = active & grant_alu & ~alu_empty;
  assign ls_pop   = active & grant_ls & ~ls_empty;
  assign alu_push = alu_live & ~alu_byp;
  assign ls_push  = ls_live & ~ls_byp;

  always_comb begin
    ptr_d  = ptr_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (flush) begin
      ptr_d = SRC_ALU;
      tag_d = NO_TAG;
    end else begin
      if (alu_req && ls_req) ptr_d = other_src(ptr_q);
      if (grant_alu) begin
        tag_d  = alu_byp ? alu_tag  : alu_head[DATA_W +: TAG_W];
        data_d = alu_byp ? alu_data : alu_head[DATA_W-1:0];
      end else if (grant_ls) begin
        tag_d  = ls_byp ? ls_tag  : ls_head[DATA_W +: TAG_W];
        data_d = ls_byp ? ls_data : ls_head[DATA_W-1:0];
      end else begin
        tag_d = NO_TAG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= SRC_ALU;
      tag_q  <= NO_TAG;
      data_q <= '0;
    end else if (ena) begin
      ptr_q  <= ptr_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign cdb_tag  = tag_q;
  assign cdb_data = data_q;

  cdb_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .ena_i   (ena),
    .flush_i (flush),
    .push_i  (alu_push),
    .pop_i   (alu_pop),
    .wdat_i  ({alu_tag, alu_data}),
    .head_o  (alu_head),
    .empty_o (alu_empty),
    .count_o (alu_cnt)
  );

  cdb_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_ls_fifo (
    .clk     (clk),
    .rst     (rst),
    .ena_i   (ena),
    .flush_i (flush),
    .push_i  (ls_push),
    .pop_i   (ls_pop),
    .wdat_i  ({ls_tag, ls_data}),
    .head_o  (ls_head),
    .empty_o (ls_empty),
    .count_o (ls_cnt)
  );

endmodule
